// File: rtl/intc_pkg.sv
// intc_pkg: shared register offsets, FSM state type, reset constants and the
// vector-encoding helper for the intc_ctrl interrupt controller.
package intc_pkg;

    localparam logic [2:0] OFF_PEND = 3'd0;
    localparam logic [2:0] OFF_MASK = 3'd1;
    localparam logic [2:0] OFF_EDGE = 3'd2;
    localparam logic [2:0] OFF_VECT = 3'd3;
    localparam logic [2:0] OFF_EOI  = 3'd4;

    localparam logic [7:0] MASK_RST = 8'h00;
    localparam logic [7:0] EDGE_RST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } st_t;

    // {valid, 4'b0, idx} of the lowest set bit; 0x00 when nothing is active.
    function automatic logic [7:0] vect_of(input logic [7:0] act);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) v = {1'b1, 4'b0000, 3'(i)};
        end
        return v;
    endfunction

endpackage

// File: rtl/intc_if.sv
// intc_if: CPU address/strobe signals, peripheral requests and the CPU
// interrupt line. The bidirectional data bus is a plain port of intc_ctrl.
interface intc_if #(
    parameter int NUM_SRC = 8
);
    logic [15:0]        addr;
    logic               re;
    logic               we;
    logic [NUM_SRC-1:0] src;
    logic               irq_n;

    modport master (output addr, re, we, src, input irq_n);
    modport slave  (input addr, re, we, src, output irq_n);
endinterface

// File: rtl/intc_src_cap.sv
// intc_src_cap: capture of one request line into its PEND bit.
// Optional macro INTC_SYNC_EN inserts a 2-flop synchronizer in front of capture.
module intc_src_cap (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic edge_sel,
    input  logic clr,
    output logic pend
);

    logic smp;
    logic hist_q;

`ifdef INTC_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer for an asynchronous request line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b00;
        else      sync_q <= {sync_q[0], src};
    end

    assign smp = sync_q[1];
`else
    assign smp = src;
`endif

    // Previous sample for rising-edge detection, and the PEND bit itself:
    // a rising edge beats a simultaneous write-1-to-clear; level mode follows the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= 1'b0;
            pend   <= 1'b0;
        end else begin
            hist_q <= smp;
            if (edge_sel) pend <= (smp & ~hist_q) | (pend & ~clr);
            else          pend <= smp;
        end
    end

endmodule

// File: rtl/intc_ctrl.sv
// intc_ctrl: memory-mapped 8-source interrupt controller with mask, fixed
// priority (lowest index wins) and one irq_n pulse per service episode.
// Optional macro INTC_SYNC_EN (see intc_src_cap) synchronizes the src lines.
module intc_ctrl
    import intc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          NUM_SRC   = 8,
    parameter int          PULSE_LEN = 2
) (
    input  logic     clk,
    input  logic     rst,
    inout  wire [7:0] data,
    intc_if.slave    bus
);

    localparam logic [3:0] PULSE_INIT = 4'(PULSE_LEN);
    localparam logic [7:0] SRC_BITS   = 8'((1 << NUM_SRC) - 1);

    logic       hit;
    logic [2:0] off;
    logic       wr_en;
    logic       eoi;
    logic [7:0] clr;
    logic [7:0] pend;
    logic [7:0] act;
    logic [7:0] mask_q;
    logic [7:0] edge_q;
    logic [7:0] rd_data;
    st_t        st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic       irq_q, irq_d;

    assign hit   = (bus.addr[15:3] == BASE_ADDR[15:3]);
    assign off   = bus.addr[2:0];
    assign wr_en = bus.we & hit;
    assign eoi   = wr_en && (off == OFF_EOI);
    assign clr   = (wr_en && (off == OFF_PEND)) ? data : 8'h00;
    assign act   = pend & mask_q;

    // MASK and EDGE configuration registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q <= MASK_RST;
            edge_q <= EDGE_RST;
        end else if (wr_en) begin
            if (off == OFF_MASK) mask_q <= data;
            if (off == OFF_EDGE) edge_q <= data;
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_src
        if (i < NUM_SRC) begin : g_on
            intc_src_cap u_cap (
                .clk      (clk),
                .rst      (rst),
                .src      (bus.src[i]),
                .edge_sel (edge_q[i]),
                .clr      (clr[i]),
                .pend     (pend[i])
            );
        end else begin : g_off
            assign pend[i] = 1'b0;
        end
    end

    // Service-episode state, pulse counter and the registered irq_n line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q  <= IDLE;
            cnt_q <= 4'd0;
            irq_q <= 1'b1;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            irq_q <= irq_d;
        end
    end

    // Next state: pulse on pending work, count the pulse down, hold until EOI.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        irq_d = irq_q;
        case (st_q)
            IDLE: begin
                if (act != 8'h00) begin
                    st_d  = ASSERT;
                    cnt_d = PULSE_INIT;
                    irq_d = 1'b0;
                end
            end
            ASSERT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d = 4'd0;
                    st_d  = SERVICE;
                    irq_d = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) st_d = IDLE;
            end
            default: begin
                st_d  = IDLE;
                cnt_d = 4'd0;
                irq_d = 1'b1;
            end
        endcase
    end

    // Register read mux; reserved and write-only offsets read as zero.
    always_comb begin
        rd_data = 8'h00;
        case (off)
            OFF_PEND: rd_data = pend;
            OFF_MASK: rd_data = mask_q & SRC_BITS;
            OFF_EDGE: rd_data = edge_q & SRC_BITS;
            OFF_VECT: rd_data = vect_of(act);
            default:  rd_data = 8'h00;
        endcase
    end

    assign data      = (bus.re && hit && !bus.we) ? rd_data : 8'hzz;
    assign bus.irq_n = irq_q;

endmodule

// File: tb/tb_intc_ctrl.sv
// tb_intc_ctrl: table-driven directed bench for intc_ctrl plus hand-written
// sequences for service hold-off, bus release and asynchronous reset.
module tb_intc_ctrl;
    import intc_pkg::*;

    localparam logic [15:0] BASE = 16'hFF00;

    typedef struct {
        logic       wr;
        logic [2:0] woff;
        logic [7:0] wval;
        logic [7:0] srcv;
        logic       eirq;
        logic [2:0] roff;
        logic [7:0] erd;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       tb_den;
    logic [7:0] tb_data;
    wire  [7:0] data;
    int         tests;
    int         fails;
    vec_t       tbl[$];

    intc_if #(.NUM_SRC(8)) bus ();

    intc_ctrl #(.BASE_ADDR(BASE), .NUM_SRC(8), .PULSE_LEN(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .bus  (bus)
    );

    assign data = tb_den ? tb_data : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] val);
        bus.addr = BASE + 16'(off);
        tb_data  = val;
        tb_den   = 1'b1;
        bus.we   = 1'b1;
        tick();
        bus.we   = 1'b0;
        tb_den   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] off, output logic [7:0] v);
        bus.addr = BASE + 16'(off);
        bus.re   = 1'b1;
        #1;
        v = data;
        bus.re   = 1'b0;
    endtask

    task automatic add(input logic w, input logic [2:0] wo, input logic [7:0] wv,
                       input logic [7:0] s, input logic ei, input logic [2:0] ro,
                       input logic [7:0] er);
        vec_t v;
        v.wr = w; v.woff = wo; v.wval = wv; v.srcv = s;
        v.eirq = ei; v.roff = ro; v.erd = er;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] r;
        tests = 0; fails = 0;
        rst = 1'b0; tb_den = 1'b0; tb_data = 8'h00;
        bus.addr = BASE; bus.re = 1'b0; bus.we = 1'b0; bus.src = 8'h00;

        // Each row is one clock: optional write, src value, then irq_n and one register read.
        // Edge pulse on src[0]
        add(1, OFF_MASK, 8'h01, 8'h00, 1, OFF_MASK, 8'h01);
        add(1, OFF_EDGE, 8'h01, 8'h00, 1, OFF_EDGE, 8'h01);
        add(0, 3'd0,     8'h00, 8'h01, 1, OFF_PEND, 8'h01);
        add(0, 3'd0,     8'h00, 8'h00, 0, OFF_VECT, 8'h80);
        add(0, 3'd0,     8'h00, 8'h00, 0, OFF_VECT, 8'h80);
        add(0, 3'd0,     8'h00, 8'h00, 1, OFF_PEND, 8'h01);
        add(1, OFF_PEND, 8'h01, 8'h00, 1, OFF_PEND, 8'h00);
        add(1, OFF_EOI,  8'h00, 8'h00, 1, OFF_VECT, 8'h00);
        add(0, 3'd0,     8'h00, 8'h00, 1, OFF_PEND, 8'h00);
        // Two simultaneous sources, priority, W1C, EOI re-pulse
        add(1, OFF_EDGE, 8'hFF, 8'h00, 1, OFF_EDGE, 8'hFF);
        add(1, OFF_MASK, 8'hFF, 8'h00, 1, OFF_MASK, 8'hFF);
        add(0, 3'd0,     8'h00, 8'h28, 1, OFF_VECT, 8'h83);
        add(0, 3'd0,     8'h00, 8'h28, 0, OFF_VECT, 8'h83);
        add(0, 3'd0,     8'h00, 8'h00, 0, OFF_PEND, 8'h28);
        add(1, OFF_PEND, 8'h08, 8'h00, 1, OFF_VECT, 8'h85);
        add(1, OFF_EOI,  8'h00, 8'h00, 1, OFF_VECT, 8'h85);
        add(0, 3'd0,     8'h00, 8'h00, 0, OFF_PEND, 8'h20);
        add(0, 3'd0,     8'h00, 8'h00, 0, OFF_PEND, 8'h20);
        add(0, 3'd0,     8'h00, 8'h00, 1, OFF_PEND, 8'h20);
        add(1, OFF_PEND, 8'h20, 8'h00, 1, OFF_PEND, 8'h00);
        add(1, OFF_EOI,  8'h00, 8'h00, 1, OFF_VECT, 8'h00);
        // Level source ignores W1C and follows the line
        add(1, OFF_EDGE, 8'h00, 8'h00, 1, OFF_EDGE, 8'h00);
        add(0, 3'd0,     8'h00, 8'h04, 1, OFF_PEND, 8'h04);
        add(1, OFF_PEND, 8'h04, 8'h04, 0, OFF_PEND, 8'h04);
        add(0, 3'd0,     8'h00, 8'h04, 0, OFF_VECT, 8'h82);
        add(0, 3'd0,     8'h00, 8'h00, 1, OFF_PEND, 8'h00);
        add(0, 3'd0,     8'h00, 8'h00, 1, OFF_VECT, 8'h00);
        add(1, OFF_EOI,  8'h00, 8'h00, 1, OFF_PEND, 8'h00);
        // Rising edge and W1C on the same cycle: set wins
        add(1, OFF_MASK, 8'h00, 8'h00, 1, OFF_MASK, 8'h00);
        add(1, OFF_EDGE, 8'h02, 8'h00, 1, OFF_EDGE, 8'h02);
        add(1, OFF_PEND, 8'h02, 8'h02, 1, OFF_PEND, 8'h02);
        add(1, OFF_PEND, 8'h02, 8'h00, 1, OFF_PEND, 8'h00);

        // Reset state, sampled while reset is held
        tick(); tick();
        check("rst_irq_n", {7'd0, bus.irq_n}, 8'h01);
        rd(OFF_MASK, r); check("rst_mask", r, 8'h00);
        rd(OFF_EDGE, r); check("rst_edge", r, 8'hFF);
        rd(OFF_PEND, r); check("rst_pend", r, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        tick();

        foreach (tbl[i]) begin
            bus.src = tbl[i].srcv;
            if (tbl[i].wr) wr(tbl[i].woff, tbl[i].wval);
            else           tick();
            check($sformatf("row%0d_irq_n", i), {7'd0, bus.irq_n}, {7'd0, tbl[i].eirq});
            rd(tbl[i].roff, r);
            check($sformatf("row%0d_rd%0d", i, tbl[i].roff), r, tbl[i].erd);
        end

        // New request during SERVICE is held off until EOI
        wr(OFF_MASK, 8'hFF);
        wr(OFF_EDGE, 8'hFF);
        bus.src = 8'h01; tick();
        bus.src = 8'h00; tick();
        check("svc_pulse_low", {7'd0, bus.irq_n}, 8'h00);
        tick(); tick();
        check("svc_entry", {7'd0, bus.irq_n}, 8'h01);
        bus.src = 8'h10; tick();
        bus.src = 8'h00;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("svc_hold%0d", k), {7'd0, bus.irq_n}, 8'h01);
            tick();
        end
        rd(OFF_PEND, r); check("svc_pend", r, 8'h11);
        rd(OFF_VECT, r); check("svc_vect", r, 8'h80);

        // Bus released when re=0: the bench's own drive must come through intact
        bus.addr = BASE + 16'(OFF_VECT);
        bus.re = 1'b0; tb_data = 8'h00; tb_den = 1'b1;
        #1;
        check("bus_release", data, 8'h00);
        tb_den = 1'b0;

        wr(OFF_EOI, 8'h00);
        check("eoi_idle_high", {7'd0, bus.irq_n}, 8'h01);
        tick();
        check("eoi_repulse", {7'd0, bus.irq_n}, 8'h00);

        // Asynchronous reset in the middle of a pulse
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_irq_n", {7'd0, bus.irq_n}, 8'h01);
        rd(OFF_MASK, r); check("async_rst_mask", r, 8'h00);
        rd(OFF_EDGE, r); check("async_rst_edge", r, 8'hFF);
        rd(OFF_PEND, r); check("async_rst_pend", r, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_rst_irq_n", {7'd0, bus.irq_n}, 8'h01);
        rd(3'd6, r); check("rsv6_read", r, 8'h00);
        wr(3'd5, 8'hA5);
        rd(3'd5, r); check("rsv5_write_ignored", r, 8'h00);
        rd(OFF_MASK, r); check("rsv5_mask_untouched", r, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/intc_ctrl.md
# intc_ctrl

Memory-mapped interrupt controller that sits between up to eight peripheral request lines and the CPU's single `interrupt` input. It latches requests per source, applies a mask and fixed priority, and sequences one falling-edge pulse per service episode on the CPU interrupt line. It is then held off until software writes end-of-interrupt (EOI). Software reads and writes its registers through the CPU's 8-bit data / 16-bit address bus, using the CPU's `re` and `we` strobes.

## Interface
Parameters:
- `BASE_ADDR`, 16'hFF00: base of the 8-byte register window; low 3 bits must be zero.
- `NUM_SRC`, 8: number of request sources, 1..8; unused bits read 0 and are never pending.
- `PULSE_LEN`, 2: cycles `irq_n` is held low per assertion, 1..15.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `addr`  in  16  CPU address bus.
- `data`  inout  8  CPU data bus; driven only during a decoded read.
- `re`  in  1  CPU read enable; 1 = CPU not driving the bus.
- `we`  in  1  CPU write strobe, high for one clock.
- `src`  in  NUM_SRC  peripheral requests, active-high.
- `irq_n`  out  1  connects to the CPU `interrupt` input; idle high.

## Operation
Register map (offsets from `BASE_ADDR`):
- 0 PEND: read returns pending bits; writing 1 clears that bit.
- 1 MASK: read/write; 1 = enabled. Reset value 0x00.
- 2 EDGE: read/write; 1 = rising-edge source, 0 = level-high source. Reset value 0xFF.
- 3 VECT: read-only. Returns {valid, 4'b0, idx[2:0]} for the lowest-index bit of PEND & MASK. Returns 0x00 when none.
- 4 EOI: write of any value ends service.
- 5..7: reserved; read 0x00, writes ignored.

Source capture:
- Edge source: PEND bit is set when the sampled source was 0 in the previous cycle and is 1 now.
- Level source: PEND bit equals the sampled source every cycle; W1C on it has no effect.
- A simultaneous set and W1C on the same edge bit: set wins.

State machine, state `st`:
- IDLE: when PEND & MASK is nonzero, go to ASSERT, load the pulse counter with PULSE_LEN, and drive `irq_n` to 0.
- ASSERT: decrement the counter. When it reaches 0, drive `irq_n` to 1 and go to SERVICE.
- SERVICE: wait for an EOI write, then go to IDLE. New requests only accumulate in PEND.
- EOI written in IDLE or ASSERT is ignored.
- If PEND & MASK is still nonzero in IDLE after EOI, a new pulse starts on the next cycle.

Bus decode:
- Hit means `addr[15:3] == BASE_ADDR[15:3]`.
- Write: sampled at posedge `clk` with `we`=1 and hit.
- Read: `data` is driven combinationally while `re`=1 and hit and `we`=0. Otherwise `data` is high-Z.

## Timing
- Reset values: `irq_n`=1; `data`=Z; PEND=0; MASK=0x00; EDGE=0xFF; `st`=IDLE; counter=0; edge history=0.
- Capture latency, macro off: a source change sampled at posedge N is visible in PEND after posedge N.
- IRQ latency: `irq_n` falls at posedge N+1 when the bit is masked-in. It stays low exactly PULSE_LEN cycles, then rises.
- Register writes take effect after the sampling edge.
- A MASK write that enables an already-pending bit starts a pulse on the following edge, if the state is IDLE.
- Reads are combinational from current register state.
- Clearing MASK or PEND during ASSERT does not shorten the pulse.
- Reset mid-pulse forces `irq_n`=1 immediately (asynchronous).
- Minimum high time between pulses is 2 cycles: SERVICE to IDLE, then IDLE to ASSERT. This guarantees the CPU sees distinct falling edges.

## Configuration
- `INTC_SYNC_EN` defined: each `src` bit passes through a 2-flop synchronizer before edge/level capture. Capture latency increases by 2 cycles, so PEND is visible after posedge N+2 and `irq_n` falls at posedge N+3.
- Not defined: `src` is assumed synchronous to `clk` and is sampled directly.

## Structure
- Package `intc_pkg`: register offset constants (PEND, MASK, EDGE, VECT, EOI), the state enum {IDLE, ASSERT, SERVICE}, and the reset constants for MASK and EDGE.
- Sub-module `intc_src_cap`: one instance per source via generate. It contains the optional synchronizer, edge/level selection, and set/clear arbitration, and outputs its PEND bit.

## Test plan
- Reset, then MASK=0x01 and EDGE=0x01, with a 1-cycle rising pulse on `src[0]` at posedge N: PEND=0x01 after N, `irq_n` low from N+1 through N+2, VECT=0x80.
- `src[3]` and `src[5]` rise on the same cycle with MASK=0xFF: VECT=0x83. W1C 0x08, then VECT=0x85. EOI produces a second `irq_n` pulse 2 cycles later.
- Level source: EDGE=0x00, `src[2]` held high. W1C to PEND leaves bit 2 at 1. After `src[2]` drops, PEND=0 the next cycle.
- W1C of bit 1 on the same cycle `src[1]` rises: PEND bit 1 remains 1.
- During SERVICE, a new request arrives: no pulse until EOI. After EOI, IDLE is reached, and `irq_n` falls on the following edge.
- Reset asserted while `irq_n`=0: `irq_n`=1 and all registers return to reset values at once. A read of reserved offset 6 returns 0x00, and `data` is Z when `re`=0.
